// File: rtl/muldiv_exec.sv
// Iterative 32-bit multiply/divide unit for the Execute stage; owns HI/LO.
// One operand bit per cycle on magnitudes, sign fix-up in a final cycle.
module muldiv_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StartE,
  input  logic [1:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        MtHiE,
  input  logic        MtLoE,
  input  logic        AbortE,
  output logic [31:0] HiE,
  output logic [31:0] LoE,
  output logic        BusyE,
  output logic        DoneE
);

  // state | meaning
  // IDLE  | waiting for StartE; MTHI/MTLO accepted here
  // RUN   | 32 iterations, one operand bit per cycle
  // FIX   | sign correction, HI/LO written on exit
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_b, r_src_a, r_hi, r_lo;
  logic [1:0]  r_op;
  logic        r_neg_a, r_neg_b, r_done;

  logic        w_start, w_signed_in, w_a_neg_in, w_b_neg_in;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_mul_sum, w_div_part;
  logic [31:0] w_div_rem;
  logic        w_div_ge;
  logic [63:0] w_mul_step, w_div_step, w_prod;
  logic [31:0] w_quo, w_rem;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_start     = (r_state == S_IDLE) && StartE && !AbortE;
  assign w_signed_in = ~MulDivOpE[0];
  assign w_a_neg_in  = w_signed_in & SrcAE[31];
  assign w_b_neg_in  = w_signed_in & SrcBE[31];
  assign w_a_mag     = w_a_neg_in ? (32'd0 - SrcAE) : SrcAE;
  assign w_b_mag     = w_b_neg_in ? (32'd0 - SrcBE) : SrcBE;

  // Multiply: r_acc = {partial product, remaining multiplier bits}
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};

  // Divide: r_acc = {remainder, dividend bits shifting out / quotient shifting in}
  assign w_div_part = r_acc[63:31];
  assign w_div_ge   = w_div_part >= {1'b0, r_b};
  assign w_div_rem  = w_div_part[31:0] - r_b;
  assign w_div_step = w_div_ge ? {w_div_rem, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

  assign w_prod = (r_neg_a ^ r_neg_b) ? (64'd0 - r_acc) : r_acc;
  assign w_quo  = (r_neg_a ^ r_neg_b) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem  = r_neg_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_comb begin
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (r_op[1]) begin
      if (r_b == 32'd0) begin
        w_res_hi = r_src_a;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_RUN;
      S_RUN: begin
        if (AbortE)              w_next = S_IDLE;
        else if (r_cnt == 5'd0)  w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 5'd0;
      r_acc   <= 64'd0;
      r_b     <= 32'd0;
      r_src_a <= 32'd0;
      r_op    <= 2'd0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt   <= 5'd31;
            r_op    <= MulDivOpE;
            r_src_a <= SrcAE;
            r_neg_a <= w_a_neg_in;
            r_neg_b <= w_b_neg_in;
            r_acc   <= {32'd0, MulDivOpE[1] ? w_a_mag : w_b_mag};
            r_b     <= MulDivOpE[1] ? w_b_mag : w_a_mag;
          end else if (!StartE) begin
            if (MtHiE) r_hi <= SrcAE;
            if (MtLoE) r_lo <= SrcAE;
          end
        end
        S_RUN: begin
          if (!AbortE) begin
            r_acc <= r_op[1] ? w_div_step : w_mul_step;
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_FIX: begin
          if (!AbortE) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HiE   = r_hi;
  assign LoE   = r_lo;
  assign BusyE = (r_state != S_IDLE);
  assign DoneE = r_done;

endmodule

// File: tb/tb_muldiv_exec.sv
// Self-checking bench for muldiv_exec: vector table of mult/div results plus
// hand-written abort, MTHI/MTLO, simultaneous-start and mid-op reset sequences.
module tb_muldiv_exec;

  logic        clk, rst_n, StartE, MtHiE, MtLoE, AbortE;
  logic [1:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE, HiE, LoE;
  logic        BusyE, DoneE;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    string       name;
  } vec_t;
  vec_t vecs[13];

  muldiv_exec dut (
    .clk(clk), .rst_n(rst_n), .StartE(StartE), .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .MtHiE(MtHiE), .MtLoE(MtLoE), .AbortE(AbortE),
    .HiE(HiE), .LoE(LoE), .BusyE(BusyE), .DoneE(DoneE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is just after a negedge; the op is sampled at the next posedge (T).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string name,
                        input logic with_mtlo);
    int busy_cnt;
    logic done_seen, stable;
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b; MtLoE = with_mtlo;
    @(posedge clk); #1;
    StartE = 1'b0; MtLoE = 1'b0;
    SrcAE = $urandom; SrcBE = $urandom; MulDivOpE = 2'($urandom);
    busy_cnt = 0; done_seen = 1'b0; stable = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (BusyE) busy_cnt++;
      if (DoneE) done_seen = 1'b1;
      if (HiE !== m_hi || LoE !== m_lo) stable = 1'b0;
      if (k == 5) StartE = 1'b1;
      if (k == 6) StartE = 1'b0;
    end
    chk($sformatf("%s_busy_cycles", name), busy_cnt, 33);
    chk($sformatf("%s_done_early", name), {31'd0, done_seen}, 32'd0);
    chk($sformatf("%s_hilo_stable", name), {31'd0, stable}, 32'd1);
    @(negedge clk);
    chk($sformatf("%s_busy_end", name), {31'd0, BusyE}, 32'd0);
    chk($sformatf("%s_done", name), {31'd0, DoneE}, 32'd1);
    chk($sformatf("%s_hi", name), HiE, eh);
    chk($sformatf("%s_lo", name), LoE, el);
    m_hi = eh; m_lo = el;
    @(negedge clk);
    chk($sformatf("%s_done_pulse", name), {31'd0, DoneE}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
    vecs[3]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0"};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
    vecs[5]  = '{OP_MULT,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "mult_shift4"};
    vecs[6]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100by7"};
    vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2"};
    vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0"};
    vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"};
    vecs[10] = '{OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, "multu_carry"};
    vecs[11] = '{OP_DIV,   32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, "div_zero_num"};
    vecs[12] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1sq"};

    rst_n = 1'b0; StartE = 1'b0; MtHiE = 1'b0; MtLoE = 1'b0; AbortE = 1'b0;
    MulDivOpE = 2'b00; SrcAE = 32'd0; SrcBE = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, BusyE}, 32'd0);
    chk("reset_done", {31'd0, DoneE}, 32'd0);
    chk("reset_hi", HiE, 32'd0);
    chk("reset_lo", LoE, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name, 1'b0);

    // MTHI+MTLO together in IDLE
    MtHiE = 1'b1; MtLoE = 1'b1; SrcAE = 32'h1111_1111;
    @(posedge clk); #1; MtHiE = 1'b0; MtLoE = 1'b0;
    @(negedge clk);
    chk("mt_both_hi", HiE, 32'h1111_1111);
    chk("mt_both_lo", LoE, 32'h1111_1111);
    m_hi = 32'h1111_1111; m_lo = 32'h1111_1111;

    // AbortE in IDLE blocks StartE; MtHiE ignored because StartE is high
    StartE = 1'b1; AbortE = 1'b1; MtHiE = 1'b1; SrcAE = 32'h3333_3333; SrcBE = 32'd5;
    @(posedge clk); #1; StartE = 1'b0; AbortE = 1'b0; MtHiE = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", {31'd0, BusyE}, 32'd0);
    chk("idle_abort_hi", HiE, 32'h1111_1111);

    // Abort in RUN at cycle T+10, with an MTHI attempt while busy
    StartE = 1'b1; MulDivOpE = OP_MULTU; SrcAE = 32'd3; SrcBE = 32'd5;
    @(posedge clk); #1; StartE = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) chk("abort_busy_t1", {31'd0, BusyE}, 32'd1);
      if (k == 5) begin MtHiE = 1'b1; SrcAE = 32'h2222_2222; end
      if (k == 6) MtHiE = 1'b0;
      if (k == 10) AbortE = 1'b1;
    end
    @(posedge clk); #1; AbortE = 1'b0;
    @(negedge clk);
    chk("abort_busy_t11", {31'd0, BusyE}, 32'd0);
    chk("abort_done_t11", {31'd0, DoneE}, 32'd0);
    chk("abort_hi", HiE, 32'h1111_1111);
    chk("abort_lo", LoE, 32'h1111_1111);
    @(negedge clk);
    chk("abort_done_t12", {31'd0, DoneE}, 32'd0);

    // StartE and MtLoE together: the op wins, LO gets the product
    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'h0000_002A, "start_mtlo", 1'b1);

    // Reset in the middle of an op, then a clean op right after release
    StartE = 1'b1; MulDivOpE = OP_MULT; SrcAE = 32'd5; SrcBE = 32'd9;
    @(posedge clk); #1; StartE = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, BusyE}, 32'd0);
    chk("midreset_done", {31'd0, DoneE}, 32'd0);
    chk("midreset_hi", HiE, 32'd0);
    chk("midreset_lo", LoE, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_exec.md
MULDIV_EXEC -- requirements
Module: muldiv_exec

Iterative multiply/divide unit in the Execute stage; HI/LO owner; sits upstream of the E-to-M pipeline register and the hazard unit.

Interface
REQ-001 The module SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- StartE  in  1  request a mult/div op this cycle.
- MulDivOpE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcAE  in  32  multiplicand / dividend / MTHI-MTLO data.
- SrcBE  in  32  multiplier / divisor.
- MtHiE  in  1  write SrcAE to HI.
- MtLoE  in  1  write SrcAE to LO.
- AbortE  in  1  cancel the op in progress (exception flush).
- HiE  out  32  current HI register.
- LoE  out  32  current LO register.
- BusyE  out  1  op in progress; drives the hazard-unit stall.
- DoneE  out  1  one-cycle pulse when HI/LO take a result.
REQ-002 There SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-003 FSM states SHALL be IDLE, RUN and FIX; BusyE SHALL be 1 exactly when the state is not IDLE (registered, no combinational path from inputs).
REQ-004 StartE SHALL be sampled only in IDLE; at that edge the FSM latches SrcAE, SrcBE and MulDivOpE, loads the iteration counter with 31 and enters RUN.
REQ-005 StartE in RUN/FIX SHALL be ignored; the hazard unit stalls on BusyE.
REQ-006 RUN SHALL last exactly 32 cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-007 After RUN the FSM SHALL spend 1 cycle in FIX, applying sign correction and writing HI/LO at the edge that leaves FIX, then return to IDLE.
REQ-008 Latency: start sampled at edge T; BusyE high for cycles T+1..T+33; new HI/LO and DoneE=1 visible in cycle T+34; DoneE low otherwise.
REQ-009 MULT/MULTU SHALL produce the 64-bit product: HI = bits 63:32, LO = bits 31:0. MULT is two's-complement signed; MULTU is unsigned.
REQ-010 DIV/DIVU SHALL set LO = quotient truncated toward zero and HI = remainder; for DIV the remainder sign follows the dividend.
REQ-011 Divide by zero (either divide op) SHALL give LO = 0xFFFFFFFF and HI = the dividend, with normal latency.
REQ-012 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0x00000000.
REQ-013 MtHiE/MtLoE SHALL update HI/LO at the clock edge only in IDLE and only when StartE=0; otherwise they SHALL be ignored. MtHiE and MtLoE together SHALL write both registers.
REQ-014 AbortE in RUN or FIX SHALL return the FSM to IDLE at the next edge: HI/LO unchanged, DoneE not pulsed. AbortE in IDLE SHALL block a same-cycle StartE.
REQ-015 HiE/LoE SHALL always reflect the HI/LO registers; partial results SHALL never appear on them.

Reset
REQ-016 rst_n=0 SHALL immediately force state IDLE and HI, LO, counter and internal accumulators to 0, with BusyE=0 and DoneE=0, including in the middle of an op.
REQ-017 The first StartE SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-018 MULT: SrcAE=0xFFFFFFFD (-3), SrcBE=7 -> BusyE high 33 cycles; at T+34 HiE=0xFFFFFFFF, LoE=0xFFFFFFEB, DoneE=1 for one cycle.
REQ-019 MULTU: 0xFFFFFFFF x 0xFFFFFFFF -> HiE=0xFFFFFFFE, LoE=0x00000001.
REQ-020 Divide: DIV -7/2 -> LoE=0xFFFFFFFD, HiE=0xFFFFFFFF. DIVU 100/0 -> LoE=0xFFFFFFFF, HiE=0x00000064. DIV 0x80000000/-1 -> LoE=0x80000000, HiE=0.
REQ-021 Busy interactions: with HI=LO=0x11111111, pulse StartE, AbortE at cycle T+10 -> BusyE low at T+11, HI/LO stay 0x11111111, no DoneE. MtHiE while busy -> HI unchanged.
REQ-022 Simultaneous/reset: StartE+MtLoE in IDLE -> op starts, LO takes the op result rather than SrcAE. rst_n low at T+20 -> BusyE=0 and HiE=LoE=0 immediately; a new StartE after release completes normally.
